// File: rtl/tint_conflict_monitor.sv
// tint_conflict_monitor
//
// Safety stage between the T-intersection phase controller and the lamp
// drivers. Every cycle the four controller lamp codes are registered (stage 1)
// and then checked against the last accepted pattern (stage 2). Legal samples
// are forwarded to the registered lamp outputs; the first violation latches a
// sticky fault with its cause and replaces all heads with flashing amber until
// an operator clear, followed by an all-red recovery and a re-seed.
//
// Ports
//   clk                   : single clock, rising edge
//   rst_n                 : asynchronous active-low reset
//   light_LS/BR/LR/RB [3] : controller lamp codes (001 green, 010 amber, 100 red)
//   fault_clr             : single-cycle clear request, only acted on in FAULT
//   lamp_LS/BR/LR/RB  [3] : registered lamp drive
//   fault                 : sticky fault flag
//   fault_code        [3] : first cause (1 code, 2 conflict, 3 transition,
//                           4 short amber, 5 watchdog), 0 when no fault
//
// State  | meaning
// INIT   | lamps red, seed previous pattern from the sample, clear counters
// RUN    | check each sample, forward legal samples to the lamps
// FAULT  | flashing amber, cause held, waiting for fault_clr
// RECOVER| lamps red for RECOVER_CYC cycles, then INIT
module tint_conflict_monitor #(
    parameter int AMBER_MIN   = 3,
    parameter int WDOG_MAX    = 16,
    parameter int FLASH_HALF  = 4,
    parameter int RECOVER_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_LS,
    input  logic [2:0] light_BR,
    input  logic [2:0] light_LR,
    input  logic [2:0] light_RB,
    input  logic       fault_clr,
    output logic [2:0] lamp_LS,
    output logic [2:0] lamp_BR,
    output logic [2:0] lamp_LR,
    output logic [2:0] lamp_RB,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] AMB = 3'b010;
    localparam logic [2:0] RED = 3'b100;

    // Head index: 3 = LS, 2 = BR, 1 = LR, 0 = RB
    localparam logic [3:0][2:0] ALL_RED = {4{RED}};
    localparam logic [3:0][2:0] ALL_AMB = {4{AMB}};

    localparam int AW = $clog2(AMBER_MIN + 1);
    localparam int WW = $clog2(WDOG_MAX + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam int RW = $clog2(RECOVER_CYC + 1);

    localparam logic [AW-1:0] AMB_MIN_C = AW'(AMBER_MIN);
    localparam logic [WW-1:0] WD_MAX_C  = WW'(WDOG_MAX);
    localparam logic [WW-1:0] WD_LAST_C = WW'(WDOG_MAX - 1);
    localparam logic [FW-1:0] FC_LAST_C = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FH_C      = FW'(FLASH_HALF);
    localparam logic [RW-1:0] RC_LAST_C = RW'(RECOVER_CYC - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT, ST_RECOVER} state_t;

    state_t                  state_q, state_d;
    logic [3:0][2:0]         s_q;
    logic [3:0][2:0]         p_q, p_d;
    logic [3:0][2:0]         lamp_q, lamp_d;
    logic [3:0][AW-1:0]      amb_q, amb_d, amb_nx;
    logic [WW-1:0]           wd_q, wd_d, wd_nx;
    logic [FW-1:0]           fc_q, fc_d, fc_nx;
    logic [RW-1:0]           rc_q, rc_d;
    logic                    fault_q, fault_d;
    logic [2:0]              code_q, code_d;

    logic [3:0]              act;
    logic                    illegal, conflict, trans_bad, short_amb, same, wd_hit;
    logic [2:0]              cause;

    always_comb begin
        act       = '0;
        illegal   = 1'b0;
        trans_bad = 1'b0;
        short_amb = 1'b0;
        amb_nx    = '0;
        for (int h = 0; h < 4; h++) begin
            act[h] = (s_q[h] == GRN) || (s_q[h] == AMB);
            if (!((s_q[h] == GRN) || (s_q[h] == AMB) || (s_q[h] == RED)))
                illegal = 1'b1;
            if (((p_q[h] == RED) && (s_q[h] == AMB)) ||
                ((p_q[h] == AMB) && (s_q[h] == GRN)) ||
                ((p_q[h] == GRN) && (s_q[h] == RED)))
                trans_bad = 1'b1;
            // amb_q counts amber samples already accepted, so on amber->red it
            // holds the full length of the amber interval just ended.
            if ((p_q[h] == AMB) && (s_q[h] == RED) && (amb_q[h] < AMB_MIN_C))
                short_amb = 1'b1;
            if (s_q[h] == AMB)
                amb_nx[h] = (amb_q[h] == AMB_MIN_C) ? amb_q[h] : amb_q[h] + AW'(1);
        end
        // RB/LR, BR/LS, BR/RB, BR/LR
        conflict = (act[0] & act[1]) | (act[2] & act[3]) |
                   (act[2] & act[0]) | (act[2] & act[1]);
        same   = (s_q == p_q);
        wd_nx  = same ? ((wd_q == WD_MAX_C) ? wd_q : wd_q + WW'(1)) : '0;
        wd_hit = same && (wd_q >= WD_LAST_C);

        if (illegal)        cause = 3'd1;
        else if (conflict)  cause = 3'd2;
        else if (trans_bad) cause = 3'd3;
        else if (short_amb) cause = 3'd4;
        else if (wd_hit)    cause = 3'd5;
        else                cause = 3'd0;

        fc_nx = (fc_q == FC_LAST_C) ? '0 : fc_q + FW'(1);
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        lamp_d  = lamp_q;
        amb_d   = amb_q;
        wd_d    = wd_q;
        fc_d    = fc_q;
        rc_d    = rc_q;
        fault_d = fault_q;
        code_d  = code_q;
        case (state_q)
            ST_INIT: begin
                p_d     = s_q;
                amb_d   = '0;
                wd_d    = '0;
                lamp_d  = ALL_RED;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cause != 3'd0) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = cause;
                    lamp_d  = ALL_AMB;
                    fc_d    = '0;
                end else begin
                    lamp_d = s_q;
                    p_d    = s_q;
                    amb_d  = amb_nx;
                    wd_d   = wd_nx;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_RECOVER;
                    fault_d = 1'b0;
                    code_d  = 3'd0;
                    lamp_d  = ALL_RED;
                    rc_d    = '0;
                end else begin
                    fc_d   = fc_nx;
                    lamp_d = (fc_nx < FH_C) ? ALL_AMB : '0;
                end
            end
            ST_RECOVER: begin
                lamp_d = ALL_RED;
                if (rc_q == RC_LAST_C) state_d = ST_INIT;
                else                   rc_d = rc_q + RW'(1);
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            s_q     <= ALL_RED;
            p_q     <= ALL_RED;
            lamp_q  <= ALL_RED;
            amb_q   <= '0;
            wd_q    <= '0;
            fc_q    <= '0;
            rc_q    <= '0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            s_q     <= {light_LS, light_BR, light_LR, light_RB};
            p_q     <= p_d;
            lamp_q  <= lamp_d;
            amb_q   <= amb_d;
            wd_q    <= wd_d;
            fc_q    <= fc_d;
            rc_q    <= rc_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign lamp_LS    = lamp_q[3];
    assign lamp_BR    = lamp_q[2];
    assign lamp_LR    = lamp_q[1];
    assign lamp_RB    = lamp_q[0];
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
